// File: rtl/regfile_mp_if.sv
// Read/write/scoreboard bundle of the dual-port register file.
// The master side drives addresses and writes; the slave side is the register file.
interface regfile_mp_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
);
  localparam int AW = $clog2(NUM_REGS);

  logic            ready;
  logic [AW-1:0]   raddr1, raddr2;
  logic [XLEN-1:0] rdata1, rdata2;
  logic            we1, we2;
  logic [AW-1:0]   waddr1, waddr2;
  logic [XLEN-1:0] wdata1, wdata2;
  logic            sb_set;
  logic [AW-1:0]   sb_addr;
  logic            busy1, busy2;

  modport master (
    input  ready, rdata1, rdata2, busy1, busy2,
    output raddr1, raddr2, we1, waddr1, wdata1, we2, waddr2, wdata2, sb_set, sb_addr
  );
  modport slave (
    output ready, rdata1, rdata2, busy1, busy2,
    input  raddr1, raddr2, we1, waddr1, wdata1, we2, waddr2, wdata2, sb_set, sb_addr
  );
endinterface

// File: rtl/regfile_mp.sv
// 2R/2W register file with write-to-read bypass, post-reset self clear and a
// per-register busy scoreboard for issue/writeback hazard tracking.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  rf
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                         state, state_nx;
  logic [AW-1:0]                  clr_idx, clr_idx_nx;
  logic [NUM_REGS-1:0][XLEN-1:0]  regs;
  logic [NUM_REGS-1:0]            busy;

  logic run, clr_en, we1_g, we2_g, sb_g;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    if (state == CLEAR) begin
      clr_idx_nx = clr_idx + 1'b1;
      if (clr_idx == AW'(NUM_REGS - 1)) state_nx = RUN;
    end
  end

  // ---------------- FSM: outputs / qualified enables ----------------
  // Writes and scoreboard sets to x0 are dropped at the source so neither
  // the array nor the busy bits ever see them.
  always_comb begin
    run    = (state == RUN);
    clr_en = (state == CLEAR);
    we1_g  = run && rf.we1 && !(ZERO_REG != 0 && rf.waddr1 == '0);
    we2_g  = run && rf.we2 && !(ZERO_REG != 0 && rf.waddr2 == '0);
    sb_g   = run && rf.sb_set && !(ZERO_REG != 0 && rf.sb_addr == '0);
  end

  assign rf.ready = run;

  // Storage: port 2 has priority on an address collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (clr_en && clr_idx == AW'(i))       regs[i] <= '0;
      else if (we2_g && rf.waddr2 == AW'(i)) regs[i] <= rf.wdata2;
      else if (we1_g && rf.waddr1 == AW'(i)) regs[i] <= rf.wdata1;
    end
  end

  // Scoreboard: an issue to the same register as a completing write is a new
  // producer, so set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sb_g && rf.sb_addr == AW'(i))
          busy[i] <= 1'b1;
        else if ((we1_g && rf.waddr1 == AW'(i)) || (we2_g && rf.waddr2 == AW'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  // ---------------- read ports ----------------
  logic [1:0][AW-1:0]   raddr;
  logic [1:0][XLEN-1:0] rdata;
  logic [1:0]           busy_rd, hit1, hit2;

  assign raddr = {rf.raddr2, rf.raddr1};

  always_comb begin
    rdata   = '0;
    busy_rd = '0;
    hit1    = '0;
    hit2    = '0;
    for (int p = 0; p < 2; p++) begin
      hit1[p]    = we1_g && rf.waddr1 == raddr[p];
      hit2[p]    = we2_g && rf.waddr2 == raddr[p];
      rdata[p]   = regs[raddr[p]];
      busy_rd[p] = busy[raddr[p]];
      if (BYPASS != 0) begin
        if (hit1[p]) rdata[p] = rf.wdata1;
        if (hit2[p]) rdata[p] = rf.wdata2;
        // Data is being forwarded this cycle, so the consumer need not stall.
        if (hit1[p] || hit2[p]) busy_rd[p] = 1'b0;
      end
      if (!run || (ZERO_REG != 0 && raddr[p] == '0)) begin
        rdata[p]   = '0;
        busy_rd[p] = 1'b0;
      end
    end
  end

  assign rf.rdata1 = rdata[0];
  assign rf.rdata2 = rdata[1];
  assign rf.busy1  = busy_rd[0];
  assign rf.busy2  = busy_rd[1];
endmodule
